// File: rtl/nios2_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module      : nios2_cpu_div_cell
// Description : Sequential radix-2 restoring divider (div/divu), one quotient
//               bit per clock, with flush abort. Optional macro
//               NIOS2_DIV_ZERO_FAST_EN skips iteration on divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_cpu_div_cell #(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] ZERO_Q = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic              E_div_kill,
    output logic [DATA_W-1:0] div_quotient,
    output logic [DATA_W-1:0] div_remainder,
    output logic              div_busy,
    output logic              div_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic              r_signed;
    logic              r_zero;
    logic              r_q_neg;
    logic              r_r_neg;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_dsr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fix_ph;

    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_trial;
    logic              w_ge;
    logic [DATA_W-1:0] w_q_fix;
    logic [DATA_W-1:0] w_r_fix;

    always_comb begin
        w_abs1  = (r_signed && r_src1[DATA_W-1]) ? -r_src1 : r_src1;
        w_abs2  = (r_signed && r_src2[DATA_W-1]) ? -r_src2 : r_src2;
        // Partial remainder keeps one extra bit so the trial sign is the borrow
        w_shift = {r_rem, r_dvd[DATA_W-1]};
        w_trial = w_shift - {1'b0, r_dsr};
        w_ge    = ~w_trial[DATA_W];
        w_q_fix = r_zero ? ZERO_Q : (r_q_neg ? -r_dvd : r_dvd);
        w_r_fix = r_zero ? r_src1 : (r_r_neg ? -r_rem : r_rem);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_src1        <= '0;
            r_src2        <= '0;
            r_signed      <= 1'b0;
            r_zero        <= 1'b0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_rem         <= '0;
            r_dvd         <= '0;
            r_dsr         <= '0;
            r_cnt         <= '0;
            r_fix_ph      <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
            div_busy      <= 1'b0;
            div_done      <= 1'b0;
        end else begin
            div_done <= 1'b0;
            if (E_div_kill && (r_state != S_IDLE)) begin
                r_state  <= S_IDLE;
                r_fix_ph <= 1'b0;
                div_busy <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (E_div_start && !E_div_kill) begin
                            r_src1   <= E_src1;
                            r_src2   <= E_src2;
                            r_signed <= E_div_signed;
                            r_zero   <= (E_src2 == '0);
                            div_busy <= 1'b1;
                            r_state  <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        r_rem    <= '0;
                        r_dvd    <= w_abs1;
                        r_dsr    <= w_abs2;
                        r_q_neg  <= r_signed & (r_src1[DATA_W-1] ^ r_src2[DATA_W-1]);
                        r_r_neg  <= r_signed & r_src1[DATA_W-1];
                        r_cnt    <= CNT_W'(DATA_W - 1);
                        r_fix_ph <= 1'b0;
`ifdef NIOS2_DIV_ZERO_FAST_EN
                        r_state  <= r_zero ? S_FIX : S_ITER;
`else
                        r_state  <= S_ITER;
`endif
                    end
                    S_ITER: begin
                        r_rem <= w_ge ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
                        r_dvd <= {r_dvd[DATA_W-2:0], w_ge};
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == '0) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        // First FIX cycle applies the sign fix, second publishes it
                        if (!r_fix_ph) begin
                            r_dvd    <= w_q_fix;
                            r_rem    <= w_r_fix;
                            r_fix_ph <= 1'b1;
                        end else begin
                            div_quotient  <= r_dvd;
                            div_remainder <= r_rem;
                            div_done      <= 1'b1;
                            div_busy      <= 1'b0;
                            r_fix_ph      <= 1'b0;
                            r_state       <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios2_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_cpu_div_cell
// Description : Self-checking bench for nios2_cpu_div_cell (DATA_W=32) with a
//               plain-arithmetic reference model. Honours NIOS2_DIV_ZERO_FAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_cpu_div_cell;

    localparam int          DATA_W = 32;
    localparam logic [31:0] ZERO_Q = 32'hFFFF_FFFF;
    localparam int          LAT    = DATA_W + 3;
`ifdef NIOS2_DIV_ZERO_FAST_EN
    localparam int          LAT_Z  = 3;
`else
    localparam int          LAT_Z  = DATA_W + 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] E_src1 = '0;
    logic [31:0] E_src2 = '0;
    logic        E_div_start = 1'b0;
    logic        E_div_signed = 1'b0;
    logic        E_div_kill = 1'b0;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_busy;
    logic        div_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    nios2_cpu_div_cell #(.DATA_W(DATA_W), .ZERO_Q(ZERO_Q)) dut (
        .clk           (clk),
        .reset         (reset),
        .E_src1        (E_src1),
        .E_src2        (E_src2),
        .E_div_start   (E_div_start),
        .E_div_signed  (E_div_signed),
        .E_div_kill    (E_div_kill),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_busy      (div_busy),
        .div_done      (div_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // C truncation semantics via 64-bit arithmetic; no overflow at -2^31 / -1
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa, sb, qq, rr;
        if (b == 32'd0) begin
            q = ZERO_Q;
            r = a;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[31:0];
            r  = rr[31:0];
        end
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the done edge
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [31:0] q, output logic [31:0] r,
                          output int busy_err);
        E_src1 = a; E_src2 = b; E_div_signed = s; E_div_start = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        lat = 0;
        busy_err = 0;
        if (!div_busy) busy_err++;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (div_done) begin
                if (div_busy) busy_err++;
                break;
            end else if (!div_busy) begin
                busy_err++;
            end
        end
        if (!div_done) lat = -1;
        q = div_quotient;
        r = div_remainder;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        int lat, berr, elat;
        logic [31:0] q, r, eq, er;
        model(a, b, s, eq, er);
        elat = (b == 32'd0) ? LAT_Z : LAT;
        run_op(a, b, s, lat, q, r, berr);
        n_checks++;
        if (q !== eq || r !== er) begin
            n_fail++;
            $display("FAIL %s result: a=%h b=%h s=%0d got q=%h r=%h expected q=%h r=%h",
                     name, a, b, s, q, r, eq, er);
        end
        n_checks++;
        if (lat !== elat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        n_checks++;
        if (berr !== 0) begin
            n_fail++;
            $display("FAIL %s busy: %0d busy violations, expected 0", name, berr);
        end
        last_q = eq;
        last_r = er;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({div_quotient, div_remainder, div_busy, div_done} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b expected all 0",
                     div_quotient, div_remainder, div_busy, div_done);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", div_busy, div_done);
        end
    endtask

    task automatic test_unsigned();
        check_op("udiv_100_7", 32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (div_done !== 1'b0 || div_quotient !== 32'd14 || div_remainder !== 32'd2) begin
            n_fail++;
            $display("FAIL done_pulse_hold: got done=%b q=%h r=%h expected 0 0000000e 00000002",
                     div_done, div_quotient, div_remainder);
        end
    endtask

    task automatic test_signed();
        check_op("sdiv_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1);
        check_op("sdiv_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1);
        check_op("sdiv_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_op("udiv_overflow_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_div_zero();
        check_op("udiv_5_0", 32'd5, 32'd0, 1'b0);
        check_op("sdiv_m7_0", 32'hFFFF_FFF9, 32'd0, 1'b1);
    endtask

    task automatic test_kill();
        int saw_done, lat;
        logic held_bad;
        E_src1 = 32'd1000; E_src2 = 32'd10; E_div_signed = 1'b0; E_div_start = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1 E_div_kill = 1'b1;
        @(posedge clk); #1;
        E_div_kill = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (div_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_busy: got busy=%b expected 0", div_busy);
        end
        saw_done = 0;
        held_bad = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_done) saw_done++;
            if (div_quotient !== last_q || div_remainder !== last_r) held_bad = 1'b1;
        end
        n_checks++;
        if (saw_done !== 0 || held_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_no_done: got done_count=%0d outputs_changed=%b expected 0 0",
                     saw_done, held_bad);
        end
        // Simultaneous start and kill in IDLE must not be accepted
        E_src1 = 32'd50; E_src2 = 32'd5; E_div_start = 1'b1; E_div_kill = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0; E_div_kill = 1'b0;
        n_checks++;
        if (div_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_over_start: got busy=%b expected 0", div_busy);
        end
        // 9/4 with an extra start pulse mid-operation that must be ignored
        E_src1 = 32'd9; E_src2 = 32'd4; E_div_signed = 1'b0; E_div_start = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        lat = 0;
        repeat (4) begin
            @(posedge clk); #1; lat++;
        end
        E_src1 = 32'd77; E_src2 = 32'd5; E_div_start = 1'b1;
        @(posedge clk); #1; lat++;
        E_div_start = 1'b0;
        while (!div_done && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (div_quotient !== 32'd2 || div_remainder !== 32'd1 || lat !== LAT) begin
            n_fail++;
            $display("FAIL restart_9_4: got q=%h r=%h lat=%0d expected q=2 r=1 lat=%0d",
                     div_quotient, div_remainder, lat, LAT);
        end
        last_q = 32'd2; last_r = 32'd1;
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_done) saw_done++;
        end
        n_checks++;
        if (saw_done !== 0) begin
            n_fail++;
            $display("FAIL ignored_start: got %0d extra done pulses expected 0", saw_done);
        end
    endtask

    task automatic test_reset_mid();
        int saw_done;
        E_src1 = 32'hFFFF_FFFF; E_src2 = 32'd3; E_div_signed = 1'b0; E_div_start = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({div_quotient, div_remainder, div_busy, div_done} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got q=%h r=%h busy=%b done=%b expected all 0",
                     div_quotient, div_remainder, div_busy, div_done);
        end
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_done) saw_done++;
        end
        n_checks++;
        if (saw_done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", saw_done);
        end
        check_op("after_reset_ffffffff_3", 32'hFFFF_FFFF, 32'd3, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = 32'd0;
                default: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
            endcase
            s = 1'($urandom_range(0, 1));
            check_op("random", a, b, s);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
